pause_dim_ctrl: RTL and testbench

Parametrised pause/dim controller for arcade cores: merges a user pause button, N pause-request sources (hiscore, save states, etc.) and the OSD-open pause into one registered `pause_cpu`. After a configurable idle time in a user/OSD pause it dims the video. It sits between the core's RGB output and `arcade_video`, generalising the fixed-width, single-request pause with a fixed 10 s dim to arbitrary colour widths, source count, timeout and dim depth.

---
 rtl/pause_dim_ctrl.sv | 105 ++++++++++
 tb/tb_pause_dim_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pause_dim_ctrl.sv
// Pause/dim controller: merges user, OSD and external pause sources into one
// registered pause, and dims the video after a configurable idle pause time.
module pause_dim_ctrl #(
    parameter int RW        = 3,
    parameter int GW        = 3,
    parameter int BW        = 2,
    parameter int NREQ      = 2,
    parameter int CLK_HZ    = 12_000_000,
    parameter int DIM_SECS  = 10,
    parameter int DIM_SHIFT = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  user_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic                  OSD_STATUS,
    input  logic [1:0]            options,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dim_active
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = $clog2(DIM_SECS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_MAX = SW'(DIM_SECS);

    logic                  btn_q_r;
    logic                  toggle_r;
    logic [PW-1:0]         pre_r;
    logic [SW-1:0]         sec_r;

    logic                  osd_p_s;
    logic                  toggle_next_s;
    logic                  run_s;
    logic                  pause_next_s;
    logic                  dim_next_s;
    logic [PW-1:0]         pre_next_s;
    logic [SW-1:0]         sec_next_s;
    logic [RW+GW+BW-1:0]   rgb_next_s;

    // Next-state logic for toggle, dim timer, pause and video path
    always_comb begin
        osd_p_s       = OSD_STATUS & options[0];
        toggle_next_s = toggle_r ^ (user_button & ~btn_q_r);
        run_s         = (toggle_r | osd_p_s) & options[1];
        pause_next_s  = toggle_next_s | (|pause_request) | osd_p_s;
        pre_next_s    = {PW{1'b0}};
        sec_next_s    = {SW{1'b0}};
        dim_next_s    = 1'b0;

        // Leaving the pause (or disabling dim) restarts the whole timeout
        if (!run_s) begin
            pre_next_s = {PW{1'b0}};
            sec_next_s = {SW{1'b0}};
            dim_next_s = 1'b0;
        end else begin
            dim_next_s = (sec_r == SEC_MAX);
            if (pre_r == PRE_MAX) begin
                pre_next_s = {PW{1'b0}};
                if (sec_r == SEC_MAX) begin
                    sec_next_s = sec_r;
                end else begin
                    sec_next_s = sec_r + SW'(1'b1);
                end
            end else begin
                pre_next_s = pre_r + PW'(1'b1);
                sec_next_s = sec_r;
            end
        end

        // Per-component logical shift: no bits carry between r, g and b
        if (dim_active) begin
            rgb_next_s = {r >> DIM_SHIFT, g >> DIM_SHIFT, b >> DIM_SHIFT};
        end else begin
            rgb_next_s = {r, g, b};
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // History follows the button through reset so a held press is not a new edge
            btn_q_r    <= user_button;
            toggle_r   <= 1'b0;
            pre_r      <= {PW{1'b0}};
            sec_r      <= {SW{1'b0}};
            pause_cpu  <= 1'b0;
            dim_active <= 1'b0;
            rgb_out    <= {(RW+GW+BW){1'b0}};
        end else begin
            btn_q_r    <= user_button;
            toggle_r   <= toggle_next_s;
            pre_r      <= pre_next_s;
            sec_r      <= sec_next_s;
            pause_cpu  <= pause_next_s;
            dim_active <= dim_next_s;
            rgb_out    <= rgb_next_s;
        end
    end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl: table-driven pause/video vectors plus
// hand-written dim timing sequences with CLK_HZ=10, DIM_SECS=3.
module tb_pause_dim_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       user_button;
    logic [2:0] pause_request;
    logic       OSD_STATUS;
    logic [1:0] options;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic [7:0] rgb_out;
    logic       pause_cpu;
    logic       dim_active;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       btn;
        logic [2:0] req;
        logic [7:0] rgb;
        logic       exp_pause;
    } vec_t;

    vec_t tbl [22];

    pause_dim_ctrl #(
        .RW(3), .GW(3), .BW(2), .NREQ(3),
        .CLK_HZ(10), .DIM_SECS(3), .DIM_SHIFT(1)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button),
        .pause_request(pause_request), .OSD_STATUS(OSD_STATUS), .options(options),
        .r(r), .g(g), .b(b),
        .rgb_out(rgb_out), .pause_cpu(pause_cpu), .dim_active(dim_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_rgb(input logic [7:0] v);
        {r, g, b} = v;
    endtask

    initial begin
        // Reset with every input high
        reset_n = 1'b0; user_button = 1'b1; pause_request = 3'b111;
        OSD_STATUS = 1'b1; options = 2'b11; set_rgb(8'hFF);
        repeat (3) step();
        chk("rst_pause", {31'd0, pause_cpu}, 32'd0);
        chk("rst_dim", {31'd0, dim_active}, 32'd0);
        chk("rst_rgb", {24'd0, rgb_out}, 32'd0);

        reset_n = 1'b1; pause_request = 3'b000; OSD_STATUS = 1'b0; options = 2'b00;

        tbl[0]  = '{1'b1, 3'b000, 8'h12, 1'b0};  // button still held from reset
        tbl[1]  = '{1'b1, 3'b000, 8'h34, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 8'h56, 1'b0};
        tbl[3]  = '{1'b1, 3'b000, 8'h78, 1'b1};  // fresh press
        tbl[4]  = '{1'b0, 3'b000, 8'h9A, 1'b1};
        tbl[5]  = '{1'b1, 3'b000, 8'hBC, 1'b0};  // held 5 clocks: one flip
        tbl[6]  = '{1'b1, 3'b000, 8'hDE, 1'b0};
        tbl[7]  = '{1'b1, 3'b000, 8'hF0, 1'b0};
        tbl[8]  = '{1'b1, 3'b000, 8'h0F, 1'b0};
        tbl[9]  = '{1'b1, 3'b000, 8'hA5, 1'b0};
        tbl[10] = '{1'b0, 3'b000, 8'h5A, 1'b0};
        tbl[11] = '{1'b1, 3'b000, 8'hC3, 1'b1};
        tbl[12] = '{1'b0, 3'b000, 8'h3C, 1'b1};
        tbl[13] = '{1'b1, 3'b000, 8'h81, 1'b0};
        tbl[14] = '{1'b0, 3'b000, 8'h7E, 1'b0};
        tbl[15] = '{1'b0, 3'b100, 8'h01, 1'b1};  // request for 4 clocks
        tbl[16] = '{1'b0, 3'b100, 8'h02, 1'b1};
        tbl[17] = '{1'b0, 3'b100, 8'h04, 1'b1};
        tbl[18] = '{1'b0, 3'b100, 8'h08, 1'b1};
        tbl[19] = '{1'b0, 3'b000, 8'h10, 1'b0};
        tbl[20] = '{1'b0, 3'b010, 8'h20, 1'b1};
        tbl[21] = '{1'b0, 3'b000, 8'h40, 1'b0};

        for (int i = 0; i < 22; i++) begin
            user_button = tbl[i].btn;
            pause_request = tbl[i].req;
            set_rgb(tbl[i].rgb);
            step();
            chk($sformatf("tbl%0d_pause", i), {31'd0, pause_cpu}, {31'd0, tbl[i].exp_pause});
            chk($sformatf("tbl%0d_dim", i), {31'd0, dim_active}, 32'd0);
            chk($sformatf("tbl%0d_rgb", i), {24'd0, rgb_out}, {24'd0, tbl[i].rgb});
        end

        // User pause with dim enabled: dim 30 clocks after first running edge
        options = 2'b10; set_rgb(8'b111_110_11);
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        chk("dim_pause_on", {31'd0, pause_cpu}, 32'd1);
        for (int k = 1; k <= 30; k++) begin
            step();
            chk($sformatf("dim_wait%0d", k), {31'd0, dim_active}, 32'd0);
        end
        step();
        chk("dim_rise", {31'd0, dim_active}, 32'd1);
        chk("dim_rgb_lag", {24'd0, rgb_out}, {24'd0, 8'b111_110_11});
        step();
        chk("dim_rgb", {24'd0, rgb_out}, {24'd0, 8'b011_011_01});
        chk("dim_pause_hold", {31'd0, pause_cpu}, 32'd1);

        // Disable dimming while paused
        options = 2'b00;
        step();
        chk("dis_dim", {31'd0, dim_active}, 32'd0);
        chk("dis_rgb_lag", {24'd0, rgb_out}, {24'd0, 8'b011_011_01});
        chk("dis_pause", {31'd0, pause_cpu}, 32'd1);
        step();
        chk("dis_rgb", {24'd0, rgb_out}, {24'd0, 8'b111_110_11});
        user_button = 1'b1;
        step();
        user_button = 1'b0;
        chk("unpause", {31'd0, pause_cpu}, 32'd0);

        // OSD pause, closed at clock 20, then reopened for a full timeout
        options = 2'b11; OSD_STATUS = 1'b1;
        step();
        chk("osd_pause", {31'd0, pause_cpu}, 32'd1);
        for (int k = 1; k < 20; k++) begin
            step();
            chk($sformatf("osd_a%0d", k), {31'd0, dim_active}, 32'd0);
        end
        OSD_STATUS = 1'b0;
        step();
        chk("osd_close_pause", {31'd0, pause_cpu}, 32'd0);
        chk("osd_close_dim", {31'd0, dim_active}, 32'd0);
        step();
        OSD_STATUS = 1'b1;
        step();
        chk("osd_reopen", {31'd0, pause_cpu}, 32'd1);
        for (int k = 1; k < 30; k++) begin
            step();
            chk($sformatf("osd_b%0d", k), {31'd0, dim_active}, 32'd0);
        end
        step();
        chk("osd_dim_rise", {31'd0, dim_active}, 32'd1);
        step();
        chk("osd_dim_rgb", {24'd0, rgb_out}, {24'd0, 8'b011_011_01});
        OSD_STATUS = 1'b0;
        step();
        chk("osd_undim", {31'd0, dim_active}, 32'd0);
        chk("osd_unpause", {31'd0, pause_cpu}, 32'd0);
        step();
        chk("osd_undim_rgb", {24'd0, rgb_out}, {24'd0, 8'b111_110_11});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
